multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle successor to the single-cycle control unit. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives per-state datapath strobes. It stalls on a memory ready handshake, so instruction and data memories may have variable latency. It sits between the instruction register and the shared-memory multi-cycle datapath, and keeps the existing opcode map and ALUOp encoding.

## Interface
- `OP_W`, default 6: opcode and funct field width. Opcode values below are zero-extended when `OP_W` > 6.
- `ALUOP_W`, default 4: ALU operation code width, ≥4. Codes are zero-extended.
- `CNT_W`, default 32: width of the retired-instruction counter.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `op`  in  OP_W  opcode from the instruction register; sampled in DECODE.
- `funct`  in  OP_W  function field; sampled in DECODE.
- `mem_ready`  in  1  memory completes the current read/write this cycle.
- `pc_write`  out  1  load PC (PC+4 in FETCH, target in EXEC for jumps).
- `pc_write_cond`  out  1  load PC if the ALU branch condition holds.
- `ir_write`  out  1  load the instruction register.
- `i_or_d`  out  1  0 = memory address from PC, 1 = from ALU result.
- `mem_read`, `mem_write`  out  1 each  memory strobes.
- `reg_write`  out  1  register file write enable.
- `reg_dst`  out  2  00 = rt, 01 = rd, 10 = link register.
- `mem_to_reg`  out  2  00 = ALU, 01 = memory, 10 = PC.
- `alu_src`  out  1  0 = register, 1 = immediate.
- `alu_op`  out  ALUOP_W  ALU operation.
- `jump`  out  1  PC source is the jump target.
- `illegal`  out  1  one-cycle pulse on an unknown opcode.
- `retired`  out  1  one-cycle pulse when an instruction completes.
- `instr_count`  out  CNT_W  retired-instruction count; wraps modulo 2^CNT_W.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB. Encoding is free.
- Outputs are combinational from the current state and the latched `op`/`funct`.
- Every output not listed for a state is 0. No output is ever x or z.
- FETCH:
  - `mem_read`=1, `i_or_d`=0.
  - When `mem_ready`=1: `ir_write`=1, `pc_write`=1, `alu_op`=0000, go to DECODE.
  - Otherwise hold in FETCH.
- DECODE: latch `op`/`funct`. Unknown opcode: `illegal`=1, go to FETCH, `retired` stays 0, counter unchanged. Otherwise go to EXEC.
- EXEC by opcode:
  - R-type (000000): `alu_op`=0010, go to WB.
  - JR (R-type with funct=1): `jump`=1, `pc_write`=1, `retired`=1, go to FETCH. No register write.
  - ADDI 100011 / SUBI 110001 / ANDI 001111 / MULI 111000 / ORI 001110 / XORI 001100 / SLTI 001000: `alu_src`=1, `alu_op` = 0000/0001/0011/0100/0101/0110/0111 respectively, go to WB.
  - BEQ 100000 / BRG 100010 / BRL 100101 / BNE 000111 / BRZ 000110: `pc_write_cond`=1, `alu_op` = 0001/1000/1001/1010/1011 respectively, `retired`=1, go to FETCH.
  - JA 110100: `jump`=1, `pc_write`=1, `retired`=1, go to FETCH.
  - JAL 111110: JA outputs plus `reg_write`=1, `reg_dst`=10, `mem_to_reg`=10, `alu_op`=1100; `retired`=1, go to FETCH.
  - LW 010001 / SW 011001: `alu_src`=1, `alu_op`=0000, go to MEM.
- MEM:
  - Drives `i_or_d`=1, `alu_src`=1, `alu_op`=0000.
  - LW: `mem_read`=1; SW: `mem_write`=1. Hold until `mem_ready`=1.
  - Then LW goes to WB; SW asserts `retired`=1 and goes to FETCH.
- WB:
  - `reg_write`=1, `retired`=1, go to FETCH.
  - `reg_dst`: R-type 01; immediate ops and LW 00.
  - `mem_to_reg`: LW 01; others 00.
- `instr_count` increments on every cycle with `retired`=1.

## Timing
- Reset:
  - State = FETCH; latched `op`/`funct` = 0; `instr_count` = 0.
  - Outputs after reset are the FETCH values: `mem_read`=1, everything else 0 until `mem_ready`.
- `rst` mid-instruction aborts it with no write strobes in the reset cycle; `rst` overrides `mem_ready`.
- Latency with `mem_ready` held at 1:
  - Branches, jumps, JR, JAL: 3 cycles.
  - R-type, immediate ops, SW: 4 cycles.
  - LW: 5 cycles.
  - Each extra cycle with `mem_ready`=0 in FETCH or MEM adds one cycle.
- `mem_ready` is ignored outside FETCH and MEM.
- `op`/`funct` changes outside DECODE have no effect.

## Test plan
- Reset, then ADDI with `mem_ready`=1: states FETCH→DECODE→EXEC→WB; `alu_op`=0000 and `alu_src`=1 in EXEC; `reg_write`=1 and `retired`=1 in WB cycle 4; `instr_count`=1.
- LW with `mem_ready` low for 2 cycles in FETCH and 3 in MEM: `retired` in cycle 10; `mem_read`=1 and `i_or_d`=1 throughout MEM; `mem_to_reg`=01 in WB.
- BNE, JA, JAL, JR in sequence: each retires in 3 cycles. Only JAL shows `reg_write`=1, `reg_dst`=10, `mem_to_reg`=10. JR shows `reg_write`=0. BNE shows `alu_op`=1010 with `pc_write_cond`=1.
- Opcode 111111: `illegal` pulses in DECODE, returns to FETCH, `instr_count` unchanged. Then SW retires with `mem_write`=1 for exactly the `mem_ready` cycle.
- `rst` asserted in MEM of a SW with `mem_ready`=0: `mem_write` never seen with `mem_ready`=1; next cycle is FETCH; `instr_count`=0.
- With `CNT_W`=4, retire 17 instructions: `instr_count` wraps 15→0 and ends at 1.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control-to-datapath bundle for the multi-cycle control unit.
// The master side is the control FSM; the slave side is the datapath and memory.
interface multicycle_control_if #(
    parameter int unsigned OP_W    = 6,
    parameter int unsigned ALUOP_W = 4,
    parameter int unsigned CNT_W   = 32
);
    logic [OP_W-1:0]    op;
    logic [OP_W-1:0]    funct;
    logic               mem_ready;
    logic               pc_write;
    logic               pc_write_cond;
    logic               ir_write;
    logic               i_or_d;
    logic               mem_read;
    logic               mem_write;
    logic               reg_write;
    logic [1:0]         reg_dst;
    logic [1:0]         mem_to_reg;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
    logic               jump;
    logic               illegal;
    logic               retired;
    logic [CNT_W-1:0]   instr_count;

    modport master (
        input  op, funct, mem_ready,
        output pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
               reg_write, reg_dst, mem_to_reg, alu_src, alu_op, jump, illegal,
               retired, instr_count
    );

    modport slave (
        output op, funct, mem_ready,
        input  pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
               reg_write, reg_dst, mem_to_reg, alu_src, alu_op, jump, illegal,
               retired, instr_count
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with a memory-ready
// stall, per-state datapath strobes and a retired-instruction counter.
module multicycle_control #(
    parameter int unsigned OP_W    = 6,
    parameter int unsigned ALUOP_W = 4,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    multicycle_control_if.master bus
);
    typedef enum logic [2:0] {
        StFetch, StDecode, StExec, StMem, StWb
    } stateType;

    typedef enum logic [2:0] {
        ClsRtype, ClsImm, ClsBranch, ClsJa, ClsJal, ClsLw, ClsSw, ClsIllegal
    } instrClass;

    localparam logic [OP_W-1:0] OpRtype = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OpAddi  = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OpSubi  = OP_W'(6'b110001);
    localparam logic [OP_W-1:0] OpAndi  = OP_W'(6'b001111);
    localparam logic [OP_W-1:0] OpMuli  = OP_W'(6'b111000);
    localparam logic [OP_W-1:0] OpOri   = OP_W'(6'b001110);
    localparam logic [OP_W-1:0] OpXori  = OP_W'(6'b001100);
    localparam logic [OP_W-1:0] OpSlti  = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OpBeq   = OP_W'(6'b100000);
    localparam logic [OP_W-1:0] OpBrg   = OP_W'(6'b100010);
    localparam logic [OP_W-1:0] OpBrl   = OP_W'(6'b100101);
    localparam logic [OP_W-1:0] OpBne   = OP_W'(6'b000111);
    localparam logic [OP_W-1:0] OpBrz   = OP_W'(6'b000110);
    localparam logic [OP_W-1:0] OpJa    = OP_W'(6'b110100);
    localparam logic [OP_W-1:0] OpJal   = OP_W'(6'b111110);
    localparam logic [OP_W-1:0] OpLw    = OP_W'(6'b010001);
    localparam logic [OP_W-1:0] OpSw    = OP_W'(6'b011001);
    localparam logic [OP_W-1:0] FunctJr = OP_W'(6'b000001);

    function automatic instrClass classify(input logic [OP_W-1:0] o);
        instrClass cls;
        case (o)
            OpRtype:                                      cls = ClsRtype;
            OpAddi, OpSubi, OpAndi, OpMuli,
            OpOri, OpXori, OpSlti:                        cls = ClsImm;
            OpBeq, OpBrg, OpBrl, OpBne, OpBrz:            cls = ClsBranch;
            OpJa:                                         cls = ClsJa;
            OpJal:                                        cls = ClsJal;
            OpLw:                                         cls = ClsLw;
            OpSw:                                         cls = ClsSw;
            default:                                      cls = ClsIllegal;
        endcase
        return cls;
    endfunction

    // ALU code for immediate and branch ops; ADDI/LW/SW fall through to add.
    function automatic logic [3:0] aluCode(input logic [OP_W-1:0] o);
        logic [3:0] code;
        case (o)
            OpSubi, OpBeq: code = 4'b0001;
            OpAndi:        code = 4'b0011;
            OpMuli:        code = 4'b0100;
            OpOri:         code = 4'b0101;
            OpXori:        code = 4'b0110;
            OpSlti:        code = 4'b0111;
            OpBrg:         code = 4'b1000;
            OpBrl:         code = 4'b1001;
            OpBne:         code = 4'b1010;
            OpBrz:         code = 4'b1011;
            default:       code = 4'b0000;
        endcase
        return code;
    endfunction

    stateType         state;
    logic [OP_W-1:0]  opLatch;
    logic [OP_W-1:0]  functLatch;
    logic [CNT_W-1:0] instrCount;
    instrClass        latchedCls;
    logic             isJr;

    logic       pcWrite, pcWriteCond, irWrite, iOrD, memRead, memWrite, regWrite;
    logic [1:0] regDst, memToReg;
    logic       aluSrc, jump, illegal, retired;
    logic [3:0] aluOpC;

    assign latchedCls = classify(opLatch);
    assign isJr       = (latchedCls == ClsRtype) && (functLatch == FunctJr);

    // State sequencing, opcode latch and retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StFetch;
            opLatch    <= '0;
            functLatch <= '0;
            instrCount <= '0;
        end else begin
            if (retired) begin
                instrCount <= instrCount + CNT_W'(1);
            end
            case (state)
                StFetch: begin
                    if (bus.mem_ready) begin
                        state <= StDecode;
                    end
                end
                StDecode: begin
                    opLatch    <= bus.op;
                    functLatch <= bus.funct;
                    state      <= (classify(bus.op) == ClsIllegal) ? StFetch : StExec;
                end
                StExec: begin
                    case (latchedCls)
                        ClsRtype:     state <= isJr ? StFetch : StWb;
                        ClsImm:       state <= StWb;
                        ClsLw, ClsSw: state <= StMem;
                        default:      state <= StFetch;
                    endcase
                end
                StMem: begin
                    if (bus.mem_ready) begin
                        state <= (latchedCls == ClsLw) ? StWb : StFetch;
                    end
                end
                default: state <= StFetch;
            endcase
        end
    end

    // Per-state strobes; everything is forced low while rst is asserted.
    always_comb begin
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        irWrite     = 1'b0;
        iOrD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        regWrite    = 1'b0;
        regDst      = 2'b00;
        memToReg    = 2'b00;
        aluSrc      = 1'b0;
        aluOpC      = 4'b0000;
        jump        = 1'b0;
        illegal     = 1'b0;
        retired     = 1'b0;
        if (!rst) begin
            case (state)
                StFetch: begin
                    memRead = 1'b1;
                    if (bus.mem_ready) begin
                        irWrite = 1'b1;
                        pcWrite = 1'b1;
                    end
                end
                StDecode: begin
                    illegal = (classify(bus.op) == ClsIllegal);
                end
                StExec: begin
                    case (latchedCls)
                        ClsRtype: begin
                            if (isJr) begin
                                jump    = 1'b1;
                                pcWrite = 1'b1;
                                retired = 1'b1;
                            end else begin
                                aluOpC = 4'b0010;
                            end
                        end
                        ClsImm: begin
                            aluSrc = 1'b1;
                            aluOpC = aluCode(opLatch);
                        end
                        ClsBranch: begin
                            pcWriteCond = 1'b1;
                            aluOpC      = aluCode(opLatch);
                            retired     = 1'b1;
                        end
                        ClsJa: begin
                            jump    = 1'b1;
                            pcWrite = 1'b1;
                            retired = 1'b1;
                        end
                        ClsJal: begin
                            jump     = 1'b1;
                            pcWrite  = 1'b1;
                            regWrite = 1'b1;
                            regDst   = 2'b10;
                            memToReg = 2'b10;
                            aluOpC   = 4'b1100;
                            retired  = 1'b1;
                        end
                        ClsLw, ClsSw: begin
                            aluSrc = 1'b1;
                        end
                        default: ;
                    endcase
                end
                StMem: begin
                    iOrD   = 1'b1;
                    aluSrc = 1'b1;
                    if (latchedCls == ClsLw) begin
                        memRead = 1'b1;
                    end else begin
                        memWrite = 1'b1;
                        retired  = bus.mem_ready;
                    end
                end
                StWb: begin
                    regWrite = 1'b1;
                    retired  = 1'b1;
                    regDst   = (latchedCls == ClsRtype) ? 2'b01 : 2'b00;
                    memToReg = (latchedCls == ClsLw) ? 2'b01 : 2'b00;
                end
                default: ;
            endcase
        end
    end

    assign bus.pc_write      = pcWrite;
    assign bus.pc_write_cond = pcWriteCond;
    assign bus.ir_write      = irWrite;
    assign bus.i_or_d        = iOrD;
    assign bus.mem_read      = memRead;
    assign bus.mem_write     = memWrite;
    assign bus.reg_write     = regWrite;
    assign bus.reg_dst       = regDst;
    assign bus.mem_to_reg    = memToReg;
    assign bus.alu_src       = aluSrc;
    assign bus.alu_op        = ALUOP_W'(aluOpC);
    assign bus.jump          = jump;
    assign bus.illegal       = illegal;
    assign bus.retired       = retired;
    assign bus.instr_count   = instrCount;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: one 32-bit-counter instance plus a 4-bit-counter
// instance sharing the same stimulus to exercise counter wrap.
module tb_multicycle_control;
    localparam logic [5:0] OpAddi = 6'b100011;
    localparam logic [5:0] OpSlti = 6'b001000;
    localparam logic [5:0] OpBne  = 6'b000111;
    localparam logic [5:0] OpJa   = 6'b110100;
    localparam logic [5:0] OpJal  = 6'b111110;
    localparam logic [5:0] OpLw   = 6'b010001;
    localparam logic [5:0] OpSw   = 6'b011001;
    localparam logic [5:0] OpBad  = 6'b111111;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    multicycle_control_if #(.OP_W(6), .ALUOP_W(4), .CNT_W(32)) ifA ();
    multicycle_control_if #(.OP_W(6), .ALUOP_W(4), .CNT_W(4))  ifB ();

    assign ifB.op        = ifA.op;
    assign ifB.funct     = ifA.funct;
    assign ifB.mem_ready = ifA.mem_ready;

    multicycle_control #(.OP_W(6), .ALUOP_W(4), .CNT_W(32)) dutA (
        .clk(clk), .rst(rst), .bus(ifA.master)
    );
    multicycle_control #(.OP_W(6), .ALUOP_W(4), .CNT_W(4)) dutB (
        .clk(clk), .rst(rst), .bus(ifB.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // {pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write, reg_write,
    //  reg_dst, mem_to_reg, alu_src, alu_op, jump, illegal, retired}
    function automatic logic [18:0] ev(input logic pcw, pcwc, irw, iord, mr, mw, rw,
                                       input logic [1:0] rdst, m2r, input logic asrc,
                                       input logic [3:0] aop, input logic j, ill, ret);
        return {pcw, pcwc, irw, iord, mr, mw, rw, rdst, m2r, asrc, aop, j, ill, ret};
    endfunction

    function automatic logic [18:0] outVec();
        return {ifA.pc_write, ifA.pc_write_cond, ifA.ir_write, ifA.i_or_d, ifA.mem_read,
                ifA.mem_write, ifA.reg_write, ifA.reg_dst, ifA.mem_to_reg, ifA.alu_src,
                ifA.alu_op, ifA.jump, ifA.illegal, ifA.retired};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs, check the combinational strobes, advance a cycle.
    task automatic runCycle(input string tag, input logic rdy, input logic [5:0] o,
                            input logic [5:0] f, input logic [18:0] exp);
        ifA.mem_ready = rdy;
        ifA.op        = o;
        ifA.funct     = f;
        #1;
        chk(tag, 32'(outVec()), 32'(exp));
        @(negedge clk);
    endtask

    logic [18:0] eFW, eFG, eIdle, eExLs, eMemLw, eMemSw, eMemSwRet, eWbImm, eWbLw, eWbR;
    logic [18:0] eJump, eJal, eBne, eIll, eExR, eExSlti, writeMask;

    initial begin
        eFW       = ev(0,0,0,0,1,0,0,2'b00,2'b00,0,4'h0,0,0,0);
        eFG       = ev(1,0,1,0,1,0,0,2'b00,2'b00,0,4'h0,0,0,0);
        eIdle     = '0;
        eExLs     = ev(0,0,0,0,0,0,0,2'b00,2'b00,1,4'h0,0,0,0);
        eMemLw    = ev(0,0,0,1,1,0,0,2'b00,2'b00,1,4'h0,0,0,0);
        eMemSw    = ev(0,0,0,1,0,1,0,2'b00,2'b00,1,4'h0,0,0,0);
        eMemSwRet = ev(0,0,0,1,0,1,0,2'b00,2'b00,1,4'h0,0,0,1);
        eWbImm    = ev(0,0,0,0,0,0,1,2'b00,2'b00,0,4'h0,0,0,1);
        eWbLw     = ev(0,0,0,0,0,0,1,2'b00,2'b01,0,4'h0,0,0,1);
        eWbR      = ev(0,0,0,0,0,0,1,2'b01,2'b00,0,4'h0,0,0,1);
        eJump     = ev(1,0,0,0,0,0,0,2'b00,2'b00,0,4'h0,1,0,1);
        eJal      = ev(1,0,0,0,0,0,1,2'b10,2'b10,0,4'hC,1,0,1);
        eBne      = ev(0,1,0,0,0,0,0,2'b00,2'b00,0,4'hA,0,0,1);
        eIll      = ev(0,0,0,0,0,0,0,2'b00,2'b00,0,4'h0,0,1,0);
        eExR      = ev(0,0,0,0,0,0,0,2'b00,2'b00,0,4'h2,0,0,0);
        eExSlti   = ev(0,0,0,0,0,0,0,2'b00,2'b00,1,4'h7,0,0,0);
        writeMask = ev(1,1,1,0,0,1,1,2'b00,2'b00,0,4'h0,0,0,0);

        // Reset held with mem_ready high: no write strobes may leak out.
        rst = 1'b1;
        ifA.mem_ready = 1'b1;
        ifA.op = OpSw;
        ifA.funct = '0;
        repeat (2) @(negedge clk);
        #1 chk("rst_strobes", 32'(outVec() & writeMask), 32'(0));
        rst = 1'b0;
        ifA.mem_ready = 1'b0;
        #1;
        chk("reset_outs", 32'(outVec()), 32'(eFW));
        chk("reset_count", ifA.instr_count, 32'(0));
        chk("reset_count4", 32'(ifB.instr_count), 32'(0));
        @(negedge clk);

        // ADDI; op wiggles after DECODE must be ignored.
        runCycle("addi_fetch",  1, OpAddi, 0, eFG);
        runCycle("addi_decode", 1, OpAddi, 0, eIdle);
        runCycle("addi_exec",   1, OpBad,  0, eExLs);
        runCycle("addi_wb",     1, OpBad,  0, eWbImm);
        chk("addi_count", ifA.instr_count, 32'(1));

        // LW: 2 wait cycles in FETCH, 3 in MEM, retires in cycle 10.
        runCycle("lw_fetch_wait0", 0, OpLw, 0, eFW);
        runCycle("lw_fetch_wait1", 0, OpLw, 0, eFW);
        runCycle("lw_fetch",       1, OpLw, 0, eFG);
        runCycle("lw_decode",      1, OpLw, 0, eIdle);
        runCycle("lw_exec",        0, OpLw, 0, eExLs);
        runCycle("lw_mem_wait0",   0, OpLw, 0, eMemLw);
        runCycle("lw_mem_wait1",   0, OpLw, 0, eMemLw);
        runCycle("lw_mem_wait2",   0, OpLw, 0, eMemLw);
        runCycle("lw_mem_ready",   1, OpLw, 0, eMemLw);
        runCycle("lw_wb",          0, OpLw, 0, eWbLw);
        chk("lw_count", ifA.instr_count, 32'(2));

        // Three-cycle control transfers.
        runCycle("bne_fetch",  1, OpBne, 0, eFG);
        runCycle("bne_decode", 1, OpBne, 0, eIdle);
        runCycle("bne_exec",   1, OpBne, 0, eBne);
        runCycle("ja_fetch",   1, OpJa,  0, eFG);
        runCycle("ja_decode",  1, OpJa,  0, eIdle);
        runCycle("ja_exec",    1, OpJa,  0, eJump);
        runCycle("jal_fetch",  1, OpJal, 0, eFG);
        runCycle("jal_decode", 1, OpJal, 0, eIdle);
        runCycle("jal_exec",   1, OpJal, 0, eJal);
        runCycle("jr_fetch",   1, 6'b0,  6'd1, eFG);
        runCycle("jr_decode",  1, 6'b0,  6'd1, eIdle);
        runCycle("jr_exec",    1, 6'b0,  6'd0, eJump);
        chk("jumps_count", ifA.instr_count, 32'(6));

        // Illegal opcode: pulse in DECODE, back to FETCH, no retire.
        runCycle("ill_fetch",  1, OpBad, 0, eFG);
        runCycle("ill_decode", 1, OpBad, 0, eIll);
        runCycle("ill_back",   0, OpBad, 0, eFW);
        chk("ill_count", ifA.instr_count, 32'(6));

        runCycle("sw_fetch",  1, OpSw, 0, eFG);
        runCycle("sw_decode", 1, OpSw, 0, eIdle);
        runCycle("sw_exec",   1, OpSw, 0, eExLs);
        runCycle("sw_mem",    1, OpSw, 0, eMemSwRet);
        runCycle("sw_next",   0, OpSw, 0, eFW);
        chk("sw_count", ifA.instr_count, 32'(7));

        // R-type add and SLTI.
        runCycle("r_fetch",     1, 6'b0,   6'h20, eFG);
        runCycle("r_decode",    1, 6'b0,   6'h20, eIdle);
        runCycle("r_exec",      1, 6'b0,   6'h01, eExR);
        runCycle("r_wb",        1, 6'b0,   6'h01, eWbR);
        runCycle("slti_fetch",  1, OpSlti, 0, eFG);
        runCycle("slti_decode", 1, OpSlti, 0, eIdle);
        runCycle("slti_exec",   1, OpSlti, 0, eExSlti);
        runCycle("slti_wb",     1, OpSlti, 0, eWbImm);
        chk("alu_count", ifA.instr_count, 32'(9));
        chk("alu_count4", 32'(ifB.instr_count), 32'(9));

        // Reset during a stalled SW store.
        runCycle("swr_fetch",  1, OpSw, 0, eFG);
        runCycle("swr_decode", 1, OpSw, 0, eIdle);
        runCycle("swr_exec",   1, OpSw, 0, eExLs);
        runCycle("swr_mem",    0, OpSw, 0, eMemSw);
        rst = 1'b1;
        ifA.mem_ready = 1'b1;
        #1 chk("swr_rst_strobes", 32'(outVec() & writeMask), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        ifA.mem_ready = 1'b0;
        #1;
        chk("swr_post_fetch", 32'(outVec()), 32'(eFW));
        chk("swr_post_count", ifA.instr_count, 32'(0));
        chk("swr_post_count4", 32'(ifB.instr_count), 32'(0));
        @(negedge clk);

        // 17 jumps: 4-bit counter wraps 15 -> 0 and ends at 1.
        for (int i = 1; i <= 17; i++) begin
            runCycle("wrap_fetch",  1, OpJa, 0, eFG);
            runCycle("wrap_decode", 1, OpJa, 0, eIdle);
            runCycle("wrap_exec",   1, OpJa, 0, eJump);
            chk($sformatf("wrap_count4_%0d", i), 32'(ifB.instr_count), 32'(i % 16));
        end
        chk("wrap_count32", ifA.instr_count, 32'(17));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
